// File: rtl/scan_count_gen.sv
// Count/slot-select source for the 4-slot output shifter; SCAN_CNT_BCD_EN selects packed-BCD counting.
// Latency: every output is registered; the first count step lands PRESCALE cycles after entering RUN.
// Backpressure: none; start/stop are levels, load is a one-cycle strobe, and outputs are never stalled.
module scan_count_gen #(
    parameter int PRESCALE       = 1000,
    parameter int STEPS_PER_SLOT = 4,
    parameter int MAX_CNT        = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       up_dn,
    output logic [7:0] cnt,
    output logic [1:0] s,
    output logic       slot_strobe,
    output logic       wrap,
    output logic       busy
);

    localparam int PW = $clog2(PRESCALE);
    localparam int SW = (STEPS_PER_SLOT > 1) ? $clog2(STEPS_PER_SLOT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_SLOT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

`ifdef SCAN_CNT_BCD_EN
    localparam logic [7:0] CNT_TOP = 8'h99;

    function automatic logic [7:0] cnt_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] cnt_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return (v[7:4] == 4'd0) ? 8'h99 : {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Any non-decimal nibble saturates to the top of the BCD range.
    function automatic logic [7:0] cnt_clamp(input logic [7:0] v);
        return (v[7:4] > 4'd9 || v[3:0] > 4'd9) ? 8'h99 : v;
    endfunction
`else
    localparam logic [7:0] CNT_TOP = 8'(MAX_CNT);

    function automatic logic [7:0] cnt_inc(input logic [7:0] v);
        return (v == CNT_TOP) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] cnt_dec(input logic [7:0] v);
        return (v == 8'd0) ? CNT_TOP : v - 8'd1;
    endfunction

    function automatic logic [7:0] cnt_clamp(input logic [7:0] v);
        return (v > CNT_TOP) ? CNT_TOP : v;
    endfunction
`endif

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] step_q, step_d;
    logic          slot_strobe_q, slot_strobe_d;
    logic          wrap_q, wrap_d;
    logic          busy_q, busy_d;
    logic          tick;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        s_d           = s_q;
        presc_d       = presc_q;
        step_d        = step_q;
        slot_strobe_d = 1'b0;
        wrap_d        = 1'b0;
        tick          = 1'b0;

        // stop is tested first in every state so it beats a simultaneous start.
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    tick    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    s_d     = 2'd0;
                    presc_d = '0;
                    step_d  = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick && !load) begin
            cnt_d  = up_dn ? cnt_inc(cnt_q) : cnt_dec(cnt_q);
            wrap_d = up_dn ? (cnt_q == CNT_TOP) : (cnt_q == 8'd0);
            if (step_q == STEP_LAST) begin
                step_d        = '0;
                s_d           = s_q + 2'd1;
                slot_strobe_d = 1'b1;
            end else begin
                step_d = step_q + SW'(1);
            end
        end

        // A load swallows any coincident tick, including its slot bookkeeping.
        if (load) begin
            cnt_d   = cnt_clamp(load_val);
            presc_d = '0;
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            s_q           <= 2'd0;
            presc_q       <= '0;
            step_q        <= '0;
            slot_strobe_q <= 1'b0;
            wrap_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s_q           <= s_d;
            presc_q       <= presc_d;
            step_q        <= step_d;
            slot_strobe_q <= slot_strobe_d;
            wrap_q        <= wrap_d;
            busy_q        <= busy_d;
        end
    end

    assign cnt         = cnt_q;
    assign s           = s_q;
    assign slot_strobe = slot_strobe_q;
    assign wrap        = wrap_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_scan_count_gen.sv
// Directed bench for scan_count_gen with PRESCALE=4, STEPS_PER_SLOT=2, MAX_CNT=100.
module tb_scan_count_gen;

`ifdef SCAN_CNT_BCD_EN
    localparam logic [7:0] TOP      = 8'h99;
    localparam logic [7:0] AFTER6DN = 8'h93;
    localparam logic [7:0] LD_3A    = 8'h99;
`else
    localparam logic [7:0] TOP      = 8'd100;
    localparam logic [7:0] AFTER6DN = 8'd94;
    localparam logic [7:0] LD_3A    = 8'h3A;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, stop, load, up_dn;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic [1:0] s;
    logic       slot_strobe, wrap, busy;

    int n_tests = 0;
    int n_fail  = 0;

    scan_count_gen #(
        .PRESCALE       (4),
        .STEPS_PER_SLOT (2),
        .MAX_CNT        (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .load        (load),
        .load_val    (load_val),
        .up_dn       (up_dn),
        .cnt         (cnt),
        .s           (s),
        .slot_strobe (slot_strobe),
        .wrap        (wrap),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; up_dn = 1'b1; load_val = 8'd0;
        repeat (2) step();
        chk("rst_cnt", cnt, 0);
        chk("rst_s", s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", slot_strobe, 0);
        chk("rst_wrap", wrap, 0);

        // Start: busy one edge later, first tick 4 edges into RUN.
        rst_n = 1'b1; start = 1'b1;
        step();
        chk("start_busy", busy, 1);
        chk("start_cnt", cnt, 0);
        repeat (3) step();
        chk("pre_tick_cnt", cnt, 0);
        step();
        chk("tick1_cnt", cnt, 1);
        chk("tick1_strobe", slot_strobe, 0);
        repeat (4) step();
        chk("tick2_cnt", cnt, 2);
        chk("tick2_s", s, 1);
        chk("tick2_strobe", slot_strobe, 1);
        step();
        chk("strobe_one_cycle", slot_strobe, 0);

        // Pause with prescaler at 2, hold, resume.
        step();
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        chk("pause_busy", busy, 0);
        repeat (20) step();
        chk("pause_cnt", cnt, 2);
        chk("pause_s", s, 1);
        chk("pause_busy_hold", busy, 0);
        start = 1'b1;
        step();
        chk("resume_busy", busy, 1);
        step();
        chk("resume_no_tick", cnt, 2);
        step();
        chk("resume_tick_cnt", cnt, 3);
        chk("resume_no_strobe", slot_strobe, 0);

        // RUN -> PAUSE -> IDLE clears.
        start = 1'b0; stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        chk("clear_cnt", cnt, 0);
        chk("clear_s", s, 0);
        chk("clear_busy", busy, 0);

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        step();
        chk("startstop_busy", busy, 0);
        stop = 1'b0;
        step();
        chk("restart_busy", busy, 1);

        // Load on the tick edge: clamped, tick dropped, prescaler restarts.
        repeat (3) step();
        load = 1'b1; load_val = 8'd200;
        step();
        load = 1'b0;
        chk("load_clamp", cnt, TOP);
        chk("load_no_wrap", wrap, 0);
        repeat (3) step();
        chk("load_presc_restart", cnt, TOP);
        step();
        chk("up_wrap_cnt", cnt, 0);
        chk("up_wrap_pulse", wrap, 1);
        chk("up_wrap_s", s, 0);
        step();
        chk("wrap_one_cycle", wrap, 0);
        up_dn = 1'b0;
        repeat (3) step();
        chk("dn_wrap_cnt", cnt, TOP);
        chk("dn_wrap_pulse", wrap, 1);
        chk("dn_wrap_s", s, 1);
        chk("dn_wrap_strobe", slot_strobe, 1);

        // Slot rotation through 3 back to 0.
        repeat (16) step();
        chk("rot_s3", s, 3);
        repeat (8) step();
        chk("rot_s0", s, 0);
        chk("rot_strobe", slot_strobe, 1);
        chk("rot_cnt", cnt, AFTER6DN);

        // Load values, including non-decimal nibbles.
        up_dn = 1'b1; load = 1'b1; load_val = 8'h3A;
        step();
        chk("load_3A", cnt, LD_3A);
        load_val = 8'h42;
        step();
        chk("load_42", cnt, 8'h42);
`ifdef SCAN_CNT_BCD_EN
        load_val = 8'h98;
        step();
        load = 1'b0;
        chk("bcd_load_98", cnt, 8'h98);
        repeat (4) step();
        chk("bcd_99", cnt, 8'h99);
        chk("bcd_99_nowrap", wrap, 0);
        repeat (4) step();
        chk("bcd_00", cnt, 8'h00);
        chk("bcd_wrap", wrap, 1);
`else
        load = 1'b0;
        repeat (4) step();
        chk("bin_inc_43", cnt, 8'h43);
`endif

        // Reset overrides a simultaneous load.
        rst_n = 1'b0; load = 1'b1; load_val = 8'h12;
        step();
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_s", s, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wrap", wrap, 0);
        chk("mid_rst_strobe", slot_strobe, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
